// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_kbd_rx - PS/2 keyboard receiver: frame check, E0/F0 prefix folding,  |
// | valid/ready key events. Define PS2_KBD_RX_FIFO_EN for an event FIFO.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_kbd_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
`ifdef PS2_KBD_RX_FIFO_EN
  ,
  parameter int FIFO_AW     = 2
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       err_parity,
  output logic       err_timeout,
  output logic       overflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam int TW = $clog2(TIMEOUT);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic                   clk_hist_q, clk_hist_d;
  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   byte_vld_q, byte_vld_d;
  logic [7:0]             byte_q, byte_d;
  logic                   ext_flag_q, ext_flag_d, brk_flag_q, brk_flag_d;
  logic                   err_parity_q, err_parity_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   overflow_q, overflow_d;
  logic                   fall, dat_s, bad_frame, ev_vld, load;
  logic [9:0]             ev;

  always_comb begin
    clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d    = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_hist_d    = clk_sync_q[SYNC_STAGES-1];
    fall          = clk_hist_q & ~clk_sync_q[SYNC_STAGES-1];
    dat_s         = dat_sync_q[SYNC_STAGES-1];
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    tmo_d         = (state_q == S_IDLE || fall) ? '0 : tmo_q + 1'b1;
    byte_vld_d    = 1'b0;
    byte_d        = byte_q;
    err_parity_d  = 1'b0;
    err_timeout_d = 1'b0;
    bad_frame     = 1'b0;
    // An abandoned partial frame keeps any pending prefix flags.
    if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
      state_d       = S_IDLE;
      err_timeout_d = 1'b1;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s) begin
            state_d   = S_SHIFT;
            bit_cnt_d = 3'd0;
          end
        end
        S_SHIFT: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = dat_s;
          state_d  = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if ((parity_q ^ (^shift_q)) && dat_s) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            err_parity_d = 1'b1;
            bad_frame    = 1'b1;
          end
        end
      endcase
    end

    ev_vld     = 1'b0;
    ev         = {byte_q, ext_flag_q, brk_flag_q};
    ext_flag_d = ext_flag_q;
    brk_flag_d = brk_flag_q;
    if (byte_vld_q) begin
      if (byte_q == 8'hE0) begin
        ext_flag_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_flag_d = 1'b1;
      end else begin
        ev_vld     = 1'b1;
        ext_flag_d = 1'b0;
        brk_flag_d = 1'b0;
      end
    end
    if (bad_frame) begin
      ext_flag_d = 1'b0;
      brk_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q    <= '1;
      dat_sync_q    <= '1;
      clk_hist_q    <= 1'b1;
      state_q       <= S_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      tmo_q         <= '0;
      byte_vld_q    <= 1'b0;
      byte_q        <= 8'h00;
      ext_flag_q    <= 1'b0;
      brk_flag_q    <= 1'b0;
      err_parity_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      dat_sync_q    <= dat_sync_d;
      clk_hist_q    <= clk_hist_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tmo_q         <= tmo_d;
      byte_vld_q    <= byte_vld_d;
      byte_q        <= byte_d;
      ext_flag_q    <= ext_flag_d;
      brk_flag_q    <= brk_flag_d;
      err_parity_q  <= err_parity_d;
      err_timeout_q <= err_timeout_d;
      overflow_q    <= overflow_d;
    end
  end

  assign err_parity  = err_parity_q;
  assign err_timeout = err_timeout_q;
  assign overflow    = overflow_q;

`ifdef PS2_KBD_RX_FIFO_EN
  localparam int DEPTH = 1 << FIFO_AW;

  logic [9:0]       mem_q [DEPTH];
  logic [9:0]       mem_d [DEPTH];
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             full, empty, rd;
  logic [9:0]       head;

  always_comb begin
    full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
            (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    empty = (wptr_q == rptr_q);
    rd    = !empty && key_ready;
    load  = ev_vld && (!full || rd);
    mem_d = mem_q;
    if (load) mem_d[wptr_q[FIFO_AW-1:0]] = ev;
    wptr_d     = load ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = rd ? rptr_q + 1'b1 : rptr_q;
    overflow_d = overflow_q | (ev_vld & ~load);
    head       = empty ? 10'd0 : mem_q[rptr_q[FIFO_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
    mem_q <= mem_d;
  end

  assign key_valid    = !empty;
  assign key_code     = head[9:2];
  assign key_extended = head[1];
  assign key_released = head[0];
`else
  logic       key_valid_q, key_valid_d;
  logic [9:0] hold_q, hold_d;

  always_comb begin
    load        = ev_vld && (!key_valid_q || key_ready);
    hold_d      = load ? ev : hold_q;
    key_valid_d = load | (key_valid_q & ~key_ready);
    overflow_d  = overflow_q | (ev_vld & ~load);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_q <= 1'b0;
      hold_q      <= 10'd0;
    end else begin
      key_valid_q <= key_valid_d;
      hold_q      <= hold_d;
    end
  end

  assign key_valid    = key_valid_q;
  assign key_code     = hold_q[9:2];
  assign key_extended = hold_q[1];
  assign key_released = hold_q[0];
`endif

endmodule
`default_nettype wire
